// File: rtl/rect_plotter_pkg.sv
// rect_plotter_pkg
// Shared definitions for the rectangle plotter:
//   - state_t      : controller states (IDLE, ERASE, DRAW, DONE)
//   - BLACK, WHITE : default 3-bit colours
//   - SCREEN_W/H   : visible screen size (160x120) and the last visible column/row
//   - is_scan()    : true in the two states that emit one scan position per cycle
package rect_plotter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ERASE = 2'd1,
        DRAW  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] WHITE = 3'b111;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_LAST   = SCREEN_W - 1;
    localparam int Y_LAST   = SCREEN_H - 1;

    function automatic logic is_scan(input state_t s);
        return (s == ERASE) || (s == DRAW);
    endfunction

endpackage

// File: rtl/rect_plotter_if.sv
// rect_plotter_if
// Groups the request side (start + rectangle description) and the pixel
// write side (xpos/ypos/color_out/plot) plus status (busy/done).
//   master : the requester (game processor / testbench); drives requests,
//            observes status and pixels
//   slave  : the plotter itself
interface rect_plotter_if #(
    parameter int X_W = 8,
    parameter int Y_W = 7,
    parameter int C_W = 3,
    parameter int S_W = 4
) ();

    logic           start;
    logic [X_W-1:0] x0;
    logic [Y_W-1:0] y0;
    logic [S_W-1:0] w;
    logic [S_W-1:0] h;
    logic [C_W-1:0] color;
    logic           erase_en;
    logic [X_W-1:0] old_x;
    logic [Y_W-1:0] old_y;
    logic [C_W-1:0] bg_color;

    logic           busy;
    logic           done;
    logic [X_W-1:0] xpos;
    logic [Y_W-1:0] ypos;
    logic [C_W-1:0] color_out;
    logic           plot;

    modport master (
        output start, x0, y0, w, h, color, erase_en, old_x, old_y, bg_color,
        input  busy, done, xpos, ypos, color_out, plot
    );

    modport slave (
        input  start, x0, y0, w, h, color, erase_en, old_x, old_y, bg_color,
        output busy, done, xpos, ypos, color_out, plot
    );

endinterface

// File: rtl/rect_scan_counter.sv
// rect_scan_counter
// Raster-order (dx fastest) scan counter over a w x h rectangle.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   load       : restart the scan at (0,0); wins over enable
//   enable     : advance one position this cycle
//   w, h       : rectangle size (only meaningful when both are non-zero)
//   dx, dy     : current scan position
//   last       : current position is (w-1, h-1)
module rect_scan_counter #(
    parameter int S_W = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic           enable,
    input  logic [S_W-1:0] w,
    input  logic [S_W-1:0] h,
    output logic [S_W-1:0] dx,
    output logic [S_W-1:0] dy,
    output logic           last
);

    logic [S_W-1:0] dx_q, dx_d;
    logic [S_W-1:0] dy_q, dy_d;
    logic [S_W-1:0] w_m1;
    logic [S_W-1:0] h_m1;

    assign w_m1 = w - S_W'(1);
    assign h_m1 = h - S_W'(1);
    assign last = (dx_q == w_m1) && (dy_q == h_m1);
    assign dx   = dx_q;
    assign dy   = dy_q;

    always_comb begin
        dx_d = dx_q;
        dy_d = dy_q;
        if (load) begin
            dx_d = '0;
            dy_d = '0;
        end else if (enable) begin
            if (dx_q == w_m1) begin
                dx_d = '0;
                dy_d = dy_q + S_W'(1);
            end else begin
                dx_d = dx_q + S_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dx_q <= '0;
            dy_q <= '0;
        end else begin
            dx_q <= dx_d;
            dy_q <= dy_d;
        end
    end

endmodule

// File: rtl/rect_plotter.sv
// rect_plotter
// Accepts a rectangle request, optionally repaints the previous rectangle in
// the background colour, then paints the new one, one scan position per clock
// in raster order. Positions off-screen still take a cycle but do not plot.
// Ports:
//   clk, reset : clock, synchronous active-high reset (wins over everything)
//   bus        : rect_plotter_if.slave
//                requests : start, x0, y0, w, h, color, erase_en, old_x, old_y, bg_color
//                status   : busy, done
//                pixels   : xpos, ypos, color_out, plot (all registered)
module rect_plotter
    import rect_plotter_pkg::*;
#(
    parameter int X_W   = 8,
    parameter int Y_W   = 7,
    parameter int C_W   = 3,
    parameter int S_W   = 4,
    parameter int X_MAX = X_LAST,
    parameter int Y_MAX = Y_LAST
) (
    input  logic           clk,
    input  logic           reset,
    rect_plotter_if.slave  bus
);

    localparam logic [X_W:0] X_LIM = (X_W+1)'(X_MAX);
    localparam logic [Y_W:0] Y_LIM = (Y_W+1)'(Y_MAX);

    state_t         state_q, state_d;

    logic [X_W-1:0] x0_q, x0_d;
    logic [Y_W-1:0] y0_q, y0_d;
    logic [S_W-1:0] w_q, w_d;
    logic [S_W-1:0] h_q, h_d;
    logic [C_W-1:0] color_q, color_d;
    logic [X_W-1:0] old_x_q, old_x_d;
    logic [Y_W-1:0] old_y_q, old_y_d;
    logic [C_W-1:0] bg_q, bg_d;

    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [X_W-1:0] xpos_q, xpos_d;
    logic [Y_W-1:0] ypos_q, ypos_d;
    logic [C_W-1:0] cout_q, cout_d;
    logic           plot_q, plot_d;

    logic           cnt_load;
    logic           cnt_en;
    logic [S_W-1:0] dx;
    logic [S_W-1:0] dy;
    logic           last;

    logic [X_W-1:0] base_x;
    logic [Y_W-1:0] base_y;
    logic [X_W:0]   pix_x;
    logic [Y_W:0]   pix_y;
    logic           clipped;

    rect_scan_counter #(.S_W(S_W)) u_scan (
        .clk    (clk),
        .reset  (reset),
        .load   (cnt_load),
        .enable (cnt_en),
        .w      (w_q),
        .h      (h_q),
        .dx     (dx),
        .dy     (dy),
        .last   (last)
    );

    // Next state, request capture and scan counter control. The erase/draw
    // decision is made at acceptance, so erase_en needs no register: being in
    // ERASE is the stored form of it. A zero-sized rectangle skips both phases.
    always_comb begin
        state_d  = state_q;
        x0_d     = x0_q;
        y0_d     = y0_q;
        w_d      = w_q;
        h_d      = h_q;
        color_d  = color_q;
        old_x_d  = old_x_q;
        old_y_d  = old_y_q;
        bg_d     = bg_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    x0_d     = bus.x0;
                    y0_d     = bus.y0;
                    w_d      = bus.w;
                    h_d      = bus.h;
                    color_d  = bus.color;
                    old_x_d  = bus.old_x;
                    old_y_d  = bus.old_y;
                    bg_d     = bus.bg_color;
                    cnt_load = 1'b1;
                    if ((bus.w == '0) || (bus.h == '0)) begin
                        state_d = DONE;
                    end else if (bus.erase_en) begin
                        state_d = ERASE;
                    end else begin
                        state_d = DRAW;
                    end
                end
            end
            ERASE: begin
                cnt_en = 1'b1;
                if (last) begin
                    // Rewind the counter so DRAW starts at (0,0) with no gap.
                    cnt_load = 1'b1;
                    state_d  = DRAW;
                end
            end
            DRAW: begin
                cnt_en = 1'b1;
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pixel generation for the current scan position. The sum is one bit
    // wider than the coordinate so a rectangle running past the coordinate
    // range is clipped instead of wrapping back on-screen.
    always_comb begin
        base_x  = (state_q == ERASE) ? old_x_q : x0_q;
        base_y  = (state_q == ERASE) ? old_y_q : y0_q;
        pix_x   = {1'b0, base_x} + {{(X_W+1-S_W){1'b0}}, dx};
        pix_y   = {1'b0, base_y} + {{(Y_W+1-S_W){1'b0}}, dy};
        clipped = (pix_x > X_LIM) || (pix_y > Y_LIM);

        busy_d  = is_scan(state_q);
        done_d  = (state_q == DONE);
        plot_d  = 1'b0;
        xpos_d  = '0;
        ypos_d  = '0;
        cout_d  = '0;
        if (is_scan(state_q)) begin
            plot_d = !clipped;
            xpos_d = pix_x[X_W-1:0];
            ypos_d = pix_y[Y_W-1:0];
            cout_d = (state_q == ERASE) ? bg_q : color_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            x0_q    <= '0;
            y0_q    <= '0;
            w_q     <= '0;
            h_q     <= '0;
            color_q <= '0;
            old_x_q <= '0;
            old_y_q <= '0;
            bg_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            xpos_q  <= '0;
            ypos_q  <= '0;
            cout_q  <= '0;
            plot_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            w_q     <= w_d;
            h_q     <= h_d;
            color_q <= color_d;
            old_x_q <= old_x_d;
            old_y_q <= old_y_d;
            bg_q    <= bg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            xpos_q  <= xpos_d;
            ypos_q  <= ypos_d;
            cout_q  <= cout_d;
            plot_q  <= plot_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.xpos      = xpos_q;
    assign bus.ypos      = ypos_q;
    assign bus.color_out = cout_q;
    assign bus.plot      = plot_q;

endmodule

// File: tb/tb_rect_plotter.sv
// tb_rect_plotter
// Scoreboard bench: the stimulus side computes, from the rectangle rules,
// every pixel write and the done pulse with the cycle it must appear in and
// queues them; an independent monitor on the falling edge pops and compares.
module tb_rect_plotter;
    import rect_plotter_pkg::*;

    localparam int XM = 159;
    localparam int YM = 119;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    rect_plotter_if bus ();

    rect_plotter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int x;
        int y;
        int c;
        int cyc;
    } pix_t;

    pix_t plot_q[$];
    int   done_q[$];
    int   zero_q[$];

    int   cyc = 0;
    int   busy_lo = 1;
    int   busy_hi = 0;
    bit   finish_req = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectations.
    always @(negedge clk) begin
        if (!finish_req) begin
            while (plot_q.size() > 0 && plot_q[0].cyc < cyc) begin
                checkOutput("missing_plot_cycle", cyc, plot_q[0].cyc);
                void'(plot_q.pop_front());
            end
            while (done_q.size() > 0 && done_q[0] < cyc) begin
                checkOutput("missing_done_cycle", cyc, done_q[0]);
                void'(done_q.pop_front());
            end
            if (bus.plot === 1'b1) begin
                if (plot_q.size() == 0) begin
                    checkOutput("unexpected_plot", int'(bus.plot), 0);
                end else begin
                    pix_t e;
                    e = plot_q.pop_front();
                    checkOutput("plot_x", int'(bus.xpos), e.x);
                    checkOutput("plot_y", int'(bus.ypos), e.y);
                    checkOutput("plot_colour", int'(bus.color_out), e.c);
                    checkOutput("plot_cycle", cyc, e.cyc);
                end
            end
            if (bus.done === 1'b1) begin
                if (done_q.size() == 0) begin
                    checkOutput("unexpected_done", int'(bus.done), 0);
                end else begin
                    checkOutput("done_cycle", cyc, done_q.pop_front());
                end
            end
            if (zero_q.size() > 0 && zero_q[0] == cyc) begin
                void'(zero_q.pop_front());
                checkOutput("reset_busy", int'(bus.busy), 0);
                checkOutput("reset_done", int'(bus.done), 0);
                checkOutput("reset_plot", int'(bus.plot), 0);
                checkOutput("reset_xpos", int'(bus.xpos), 0);
                checkOutput("reset_ypos", int'(bus.ypos), 0);
                checkOutput("reset_colour", int'(bus.color_out), 0);
            end
            checkOutput("busy", int'(bus.busy), (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);
        end else begin
            checkOutput("plots_drained", plot_q.size(), 0);
            checkOutput("dones_drained", done_q.size(), 0);
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scrambleInputs();
        bus.x0       = 8'($urandom);
        bus.y0       = 7'($urandom);
        bus.w        = 4'($urandom);
        bus.h        = 4'($urandom);
        bus.color    = 3'($urandom);
        bus.erase_en = 1'($urandom);
        bus.old_x    = 8'($urandom);
        bus.old_y    = 7'($urandom);
        bus.bg_color = 3'($urandom);
    endtask

    // Issues one start pulse (called 1 time unit after a rising edge). When the
    // request is expected to be accepted, the reference model queues every
    // on-screen pixel at its scan slot; slot k is visible two edges after issue.
    task automatic applyStimulus(input int x0, input int y0, input int w, input int h,
                                 input int c, input bit er, input int ox, input int oy,
                                 input int bg, input bit accept,
                                 output int m, output int n);
        int k;
        m = cyc;
        k = 0;
        bus.x0       = 8'(x0);
        bus.y0       = 7'(y0);
        bus.w        = 4'(w);
        bus.h        = 4'(h);
        bus.color    = 3'(c);
        bus.erase_en = er;
        bus.old_x    = 8'(ox);
        bus.old_y    = 7'(oy);
        bus.bg_color = 3'(bg);
        bus.start    = 1'b1;
        if (accept) begin
            if (er) begin
                for (int yy = 0; yy < h; yy++) begin
                    for (int xx = 0; xx < w; xx++) begin
                        if (ox + xx <= XM && oy + yy <= YM)
                            plot_q.push_back('{ox + xx, oy + yy, bg, m + 2 + k});
                        k++;
                    end
                end
            end
            for (int yy = 0; yy < h; yy++) begin
                for (int xx = 0; xx < w; xx++) begin
                    if (x0 + xx <= XM && y0 + yy <= YM)
                        plot_q.push_back('{x0 + xx, y0 + yy, c, m + 2 + k});
                    k++;
                end
            end
            done_q.push_back(m + 2 + k);
            busy_lo = m + 2;
            busy_hi = m + 1 + k;
        end
        n = k;
        step(1);
        bus.start = 1'b0;
        scrambleInputs();
    endtask

    task automatic runOp(input int x0, input int y0, input int w, input int h,
                         input int c, input bit er, input int ox, input int oy, input int bg);
        int m;
        int n;
        applyStimulus(x0, y0, w, h, c, er, ox, oy, bg, 1'b1, m, n);
        step(n + 3);
    endtask

    initial begin
        int m;
        int n;
        int dummy_m;
        int dummy_n;
        bus.start = 1'b0;
        scrambleInputs();
        reset = 1'b1;
        step(3);
        zero_q.push_back(cyc);
        step(1);
        reset = 1'b0;
        step(2);

        // draw only
        runOp(10, 20, 3, 2, 4, 1'b0, 0, 0, 0);
        // erase then draw
        runOp(6, 5, 2, 2, 7, 1'b1, 5, 5, 0);
        // clipping at the bottom-right corner
        runOp(158, 118, 4, 3, 2, 1'b0, 0, 0, 0);
        // zero size, with and without erase
        runOp(50, 50, 0, 5, 3, 1'b0, 0, 0, 0);
        runOp(50, 50, 5, 0, 3, 1'b1, 10, 10, 1);
        // coordinate overflow past the 8-bit range
        runOp(250, 125, 8, 6, 5, 1'b1, 155, 117, 6);

        // busy rejection: a second start mid-draw must be ignored
        applyStimulus(30, 40, 5, 3, 6, 1'b0, 0, 0, 0, 1'b1, m, n);
        step(2);
        applyStimulus(90, 90, 2, 2, 1, 1'b1, 80, 80, 2, 1'b0, dummy_m, dummy_n);
        step(n + 3);

        // reset while the third pixel of a 4x4 draw is on the outputs
        applyStimulus(20, 30, 4, 4, 5, 1'b0, 0, 0, 0, 1'b1, m, n);
        step(3);
        reset = 1'b1;
        busy_hi = m + 4;
        step(1);
        plot_q.delete();
        done_q.delete();
        zero_q.push_back(cyc);
        reset = 1'b0;
        step(20);
        runOp(1, 2, 3, 3, 2, 1'b1, 4, 5, 1);

        // randomized requests, biased toward the screen edges
        for (int i = 0; i < 40; i++) begin
            int rx;
            int ry;
            int ox;
            int oy;
            rx = ($urandom_range(0, 1) == 1) ? $urandom_range(140, 255) : $urandom_range(0, 150);
            ry = ($urandom_range(0, 1) == 1) ? $urandom_range(105, 127) : $urandom_range(0, 110);
            ox = $urandom_range(0, 255);
            oy = $urandom_range(0, 127);
            runOp(rx, ry, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7),
                  1'($urandom_range(0, 1)), ox, oy, $urandom_range(0, 7));
        end

        step(5);
        finish_req = 1'b1;
        step(5);
        $display("[TB] FAIL monitor did not finish the run");
        $fatal(1, "[TB] monitor did not terminate");
    end

endmodule
